// File: rtl/seq_mul_unit.sv
// rtl/seq_mul_unit.sv - iterative shift-and-add multiplier sharing one WIDTH-bit adder
//
// Purpose: produces the 2*WIDTH-bit product of two WIDTH-bit operands, one
// partial-product add per clock, through a single WIDTH-bit adder instance.
// Optional feature macro: SIGNED_MUL_EN (two's-complement operands; adds FIX state).
//
// Ports (seq_mul_unit):
//   clk      in   1        rising-edge clock
//   rst      in   1        synchronous active-high reset
//   start    in   1        request, accepted only in IDLE or DONE
//   mcand    in   WIDTH    multiplicand, latched on accept
//   mplier   in   WIDTH    multiplier, latched on accept
//   busy     out  1        multiply in progress
//   done     out  1        one-cycle pulse, product valid
//   product  out  2*WIDTH  result, held until the next completed multiply
//
// Ports (adder):
//   a, b     in   WIDTH    addends
//   sum      out  WIDTH    a + b modulo 2^WIDTH
//   carry    out  1        carry out of the MSB

module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

module seq_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SIGNED_MUL_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, FIX} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     mc;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_step;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 last_iter;
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_carry;
  logic [WIDTH-1:0]     mc_in;
  logic [WIDTH-1:0]     mp_in;

`ifdef SIGNED_MUL_EN
  logic neg;

  // Work on magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
  assign mc_in = mcand[WIDTH-1]  ? (~mcand  + WIDTH'(1)) : mcand;
  assign mp_in = mplier[WIDTH-1] ? (~mplier + WIDTH'(1)) : mplier;
`else
  assign mc_in = mcand;
  assign mp_in = mplier;
`endif

  // Upper half of acc accumulates partial products; lower half holds the
  // not-yet-consumed multiplier bits, whose LSB selects this step's addend.
  assign add_b = acc[0] ? mc : '0;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a     (acc[2*WIDTH-1:WIDTH]),
    .b     (add_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Shift right by one, keeping the adder carry as the new MSB.
  assign acc_step = {add_carry, add_sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_iter = (cnt == LAST_CNT);
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
`ifdef SIGNED_MUL_EN
          state_nxt = FIX;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SIGNED_MUL_EN
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mc      <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef SIGNED_MUL_EN
      neg     <= 1'b0;
`endif
    end else if (accept) begin
      mc  <= mc_in;
      acc <= {{WIDTH{1'b0}}, mp_in};
      cnt <= '0;
`ifdef SIGNED_MUL_EN
      neg <= mcand[WIDTH-1] ^ mplier[WIDTH-1];
`endif
    end else if (state == RUN) begin
      acc <= acc_step;
      cnt <= cnt + CW'(1);
`ifndef SIGNED_MUL_EN
      // product is only written on the way into DONE, so it holds during RUN.
      if (last_iter) begin
        product <= acc_step;
      end
`endif
    end
`ifdef SIGNED_MUL_EN
    else if (state == FIX) begin
      product <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
    end
`endif
  end

endmodule

// File: tb/tb_seq_mul_unit.sv
// tb/tb_seq_mul_unit.sv - scoreboard bench for seq_mul_unit

module tb_seq_mul_unit;

  localparam int W = 32;
`ifdef SIGNED_MUL_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  seq_mul_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   done_prev = 1'b0;
  bit   seen;
  logic [31:0] ra;
  logic [31:0] rb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef SIGNED_MUL_EN
    longint sa;
    longint sb_;
    sa  = $signed(a);
    sb_ = $signed(b);
    return 64'(sa * sb_);
`else
    return {32'b0, a} * {32'b0, b};
`endif
  endfunction

  // Scoreboard: every done pops one expected product and its accept cycle.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        cur = sb.pop_front();
        check("product", product, cur.prod);
        check("latency", 64'(cyc - cur.acc_cyc), 64'(LAT));
      end
      check("done_pulse_width", 64'(done_prev), 64'd0);
    end
    done_prev = done;
  end

  // Call at a negedge with the DUT in IDLE or DONE; returns at the done negedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    int          nb;
    int          hold_viol;
    logic [63:0] p0;
    bit          got_done;
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    sb.push_back('{exp, cyc + 1});
    p0        = product;
    nb        = 0;
    hold_viol = 0;
    got_done  = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    mcand  = $urandom;
    mplier = $urandom;
    for (int i = 0; i < LAT + 8; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) nb++;
      if (product !== p0) hold_viol++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 64'(got_done), 64'd1);
    check({tag, "_busy_cycles"}, 64'(nb), 64'(LAT));
    check({tag, "_product_hold"}, 64'(hold_viol), 64'd0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef SIGNED_MUL_EN
    run_op(32'h8000_0000, 32'h4000_0000, 64'hE000_0000_0000_0000, "large");
`else
    run_op(32'h8000_0000, 32'h4000_0000, 64'h2000_0000_0000_0000, "large");
`endif
    @(negedge clk);

`ifdef SIGNED_MUL_EN
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "carry");
`else
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "carry");
`endif
    @(negedge clk);

    // Zero operand, ignored restart while busy, then back-to-back start on done.
    mcand  = 32'd0;
    mplier = 32'h1234_5678;
    start  = 1'b1;
    sb.push_back('{64'd0, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    mcand  = 32'd7;
    mplier = 32'd9;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    mcand  = $urandom;
    mplier = $urandom;
    seen   = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("zero_done_seen", 64'(seen), 64'd1);
    run_op(32'd7, 32'd9, 64'd63, "b2b");

    // Reset ten cycles into RUN aborts with no done.
    @(negedge clk);
    mcand  = 32'd3;
    mplier = 32'd4;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_product", product, 64'd0);
    repeat (LAT + 5) @(negedge clk);
    run_op(32'd3, 32'd4, 64'd12, "after_rst");
    @(negedge clk);

`ifdef SIGNED_MUL_EN
    run_op(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "neg3x5");
`else
    run_op(32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1, "neg3x5");
`endif
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minneg");

    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, model(ra, rb), "rand");
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
